// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, stability filter,
// registered edge pulses, mode-gated capture into a sticky pending flag and a
// saturating edge counter. irq_o is the OR of all pending flags.
module multi_edge_detector #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       a_i,
  input  logic [2*NUM_CH-1:0]     mode_i,
  input  logic [NUM_CH-1:0]       clear_i,
  output logic [NUM_CH-1:0]       rising_edge_o,
  output logic [NUM_CH-1:0]       falling_edge_o,
  output logic [NUM_CH-1:0]       pending_o,
  output logic                    irq_o,
  output logic [NUM_CH*CNT_W-1:0] count_o
);

  // Filter counter only ever reaches FILT_CYCLES-1, so clog2 bits suffice.
  localparam int unsigned     FCW       = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [FCW-1:0]  FILT_LAST = FCW'(FILT_CYCLES - 1);
  localparam logic [FCW-1:0]  FC_ONE    = FCW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  genvar n;
  generate
    for (n = 0; n < NUM_CH; n++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   sync_val;
      logic                   lvl_q;
      logic [FCW-1:0]         fcnt_q;
      logic                   rise_q;
      logic                   fall_q;
      logic                   capture;
      logic                   pend_q;
      logic [CNT_W-1:0]       cnt_q;

      // Synchroniser chain; the last stage is the channel's sync value
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], a_i[n]};
      end

      assign sync_val = sync_q[SYNC_STAGES-1];

      // Stability filter: accept a new level after FILT_CYCLES differing samples
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lvl_q  <= 1'b0;
          fcnt_q <= '0;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          if (sync_val == lvl_q) begin
            fcnt_q <= '0;
          end else if (fcnt_q < FILT_LAST) begin
            fcnt_q <= fcnt_q + FC_ONE;
          end else begin
            lvl_q  <= sync_val;
            fcnt_q <= '0;
            rise_q <= sync_val;
            fall_q <= ~sync_val;
          end
        end
      end

      // A pulse counts as an event only if its type is enabled right now
      always_comb begin
        capture = (rise_q & mode_i[2*n]) | (fall_q & mode_i[2*n+1]);
      end

      // Pending flag and saturating counter; a capture outranks a clear
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pend_q <= 1'b0;
          cnt_q  <= '0;
        end else if (capture) begin
          pend_q <= 1'b1;
          if (clear_i[n])           cnt_q <= CNT_ONE;
          else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
        end else if (clear_i[n]) begin
          pend_q <= 1'b0;
          cnt_q  <= '0;
        end
      end

      assign rising_edge_o[n]              = rise_q;
      assign falling_edge_o[n]             = fall_q;
      assign pending_o[n]                  = pend_q;
      assign count_o[n*CNT_W +: CNT_W]     = cnt_q;
    end
  endgenerate

  // Interrupt straight from the pending registers, no extra stage
  always_comb begin
    irq_o = |pending_o;
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: a per-cycle vector table for the
// basic detect/glitch/clear behaviour, hand sequences for mode gating,
// saturation, reset behaviour, and a randomised run against a cycle model.
module tb_multi_edge_detector;

  localparam int NCH = 4;
  localparam int SS  = 2;
  localparam int FC  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  a = '0;
  logic [7:0]  mode = '0;
  logic [3:0]  clr = '0;
  logic [3:0]  rise, fall, pend;
  logic        irq;
  logic [31:0] cnt;

  logic        a2 = 1'b0;
  logic [1:0]  mode2 = 2'b11;
  logic        clr2 = 1'b0;
  logic        rise2, fall2, pend2, irq2;
  logic [1:0]  cnt2;

  int n_checks = 0;
  int n_err    = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  multi_edge_detector dut (
    .clk(clk), .reset(reset), .a_i(a), .mode_i(mode), .clear_i(clr),
    .rising_edge_o(rise), .falling_edge_o(fall), .pending_o(pend),
    .irq_o(irq), .count_o(cnt)
  );

  multi_edge_detector #(.NUM_CH(1), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .a_i(a2), .mode_i(mode2), .clear_i(clr2),
    .rising_edge_o(rise2), .falling_edge_o(fall2), .pending_o(pend2),
    .irq_o(irq2), .count_o(cnt2)
  );

  // Reference model state
  int msync [NCH][SS];
  int mlvl  [NCH];
  int mfc   [NCH];
  int mrise [NCH];
  int mfall [NCH];
  int mpend [NCH];
  int mcnt  [NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int s = 0; s < SS; s++) msync[c][s] = 0;
      mlvl[c] = 0; mfc[c] = 0; mrise[c] = 0; mfall[c] = 0; mpend[c] = 0; mcnt[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      int cap;
      int sv;
      cap = (mrise[c] != 0 && mode[2*c]) || (mfall[c] != 0 && mode[2*c+1]);
      if (cap != 0) begin
        mpend[c] = 1;
        if (clr[c]) mcnt[c] = 1;
        else if (mcnt[c] < 255) mcnt[c] = mcnt[c] + 1;
      end else if (clr[c]) begin
        mpend[c] = 0;
        mcnt[c]  = 0;
      end
      sv = msync[c][SS-1];
      mrise[c] = 0;
      mfall[c] = 0;
      if (sv == mlvl[c]) mfc[c] = 0;
      else if (mfc[c] < FC - 1) mfc[c] = mfc[c] + 1;
      else begin
        mlvl[c] = sv;
        mfc[c]  = 0;
        if (sv != 0) mrise[c] = 1; else mfall[c] = 1;
      end
      for (int s = SS - 1; s > 0; s--) msync[c][s] = msync[c][s-1];
      msync[c][0] = a[c];
    end
  endtask

  function automatic logic [63:0] model_pack();
    logic [3:0]  r, f, p;
    logic [31:0] k;
    for (int c = 0; c < NCH; c++) begin
      r[c] = (mrise[c] != 0);
      f[c] = (mfall[c] != 0);
      p[c] = (mpend[c] != 0);
      k[c*8 +: 8] = 8'(mcnt[c]);
    end
    return {19'd0, r, f, p, |p, k};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (model_on) model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  a;
    logic [7:0]  mode;
    logic [3:0]  clr;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  pend;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int nr;
    int nf;
    bit quiet;

    // ch0 rising mode, ch1 both modes (ch1 only sees a 2-sample glitch)
    tbl[0]  = '{4'h1, 8'h0D, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[1]  = '{4'h3, 8'h0D, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[2]  = '{4'h3, 8'h0D, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[3]  = '{4'h1, 8'h0D, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[4]  = '{4'h1, 8'h0D, 4'h0, 4'h1, 4'h0, 4'h0, 32'h0};
    tbl[5]  = '{4'h1, 8'h0D, 4'h0, 4'h0, 4'h0, 4'h1, 32'h1};
    tbl[6]  = '{4'h1, 8'h0D, 4'h0, 4'h0, 4'h0, 4'h1, 32'h1};
    tbl[7]  = '{4'h1, 8'h0D, 4'h1, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[8]  = '{4'h0, 8'h0D, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[9]  = '{4'h0, 8'h0D, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[10] = '{4'h0, 8'h0D, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[11] = '{4'h0, 8'h0D, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[12] = '{4'h0, 8'h0D, 4'h0, 4'h0, 4'h1, 4'h0, 32'h0};
    tbl[13] = '{4'h0, 8'h0D, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0};

    // Reset state
    tick(); tick();
    chk("reset outputs", {rise, fall, pend, irq, cnt}, 64'h0);
    chk("reset outputs dut2", {rise2, fall2, pend2, irq2, cnt2}, 64'h0);
    reset = 1'b0;

    // Table: one row per clock edge
    for (int i = 0; i < 14; i++) begin
      a = tbl[i].a; mode = tbl[i].mode; clr = tbl[i].clr;
      tick();
      chk($sformatf("tbl[%0d] rise", i), rise, tbl[i].rise);
      chk($sformatf("tbl[%0d] fall", i), fall, tbl[i].fall);
      chk($sformatf("tbl[%0d] pend/irq", i), {pend, irq}, {tbl[i].pend, |tbl[i].pend});
      chk($sformatf("tbl[%0d] count", i), cnt, tbl[i].cnt);
    end

    // ch2 falling-only mode: both pulse types appear, only falls counted
    mode = 8'h20; clr = '0; nr = 0; nf = 0;
    for (int seg = 0; seg < 4; seg++) begin
      a[2] = (seg % 2 == 0);
      for (int t = 0; t < 10; t++) begin
        tick();
        if (rise[2]) nr++;
        if (fall[2]) nf++;
        if (rise[2] && fall[2]) chk("ch2 both pulses", 1, 0);
      end
    end
    chk("ch2 rise pulses", nr, 2);
    chk("ch2 fall pulses", nf, 2);
    chk("ch2 count", cnt[23:16], 8'd2);
    chk("ch2 pending", pend, 4'b0100);

    // Saturation on a 2-bit counter, then clear colliding with a capture
    for (int k = 0; k < 5; k++) begin
      a2 = ~a2;
      repeat (5) tick();
      chk($sformatf("dut2 pulse %0d", k), {rise2, fall2}, (k % 2 == 0) ? 2'b10 : 2'b01);
      tick(); tick();
    end
    chk("dut2 saturated count", cnt2, 2'd3);
    chk("dut2 pending", {pend2, irq2}, 2'b11);
    a2 = ~a2;
    repeat (5) tick();
    chk("dut2 pulse 5", fall2, 1'b1);
    clr2 = 1'b1; tick(); clr2 = 1'b0;
    chk("dut2 clear+capture count", cnt2, 2'd1);
    chk("dut2 clear+capture pend", pend2, 1'b1);
    clr2 = 1'b1; tick(); clr2 = 1'b0;
    chk("dut2 clear only", {pend2, cnt2}, 3'b000);

    // Input high through reset gives one rising pulse at the 5th edge
    a = 4'b0001; mode = 8'h03;
    reset = 1'b1;
    tick(); tick();
    chk("in reset outputs", {rise, fall, pend, irq, cnt}, 64'h0);
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("post-reset edge %0d rise", i), rise, (i == 5) ? 4'b0001 : 4'b0000);
    end
    chk("post-reset capture", {pend, cnt}, {4'b0001, 32'h1});

    // Reset mid-filter aborts the falling transition
    a = 4'b0000;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1 chk("async reset clears", {rise, fall, pend, irq, cnt}, 64'h0);
    tick();
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({rise, fall, pend, irq, cnt} !== '0) quiet = 1'b0;
    end
    chk("no pulse after aborted filter", quiet, 1'b1);

    // Randomised run against the cycle model
    a = '0; mode = '0; clr = '0;
    reset = 1'b1;
    tick();
    model_reset();
    reset = 1'b0;
    model_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(7) == 0) a[c] = ~a[c];
      if ($urandom_range(31) == 0) mode = 8'($urandom);
      clr = ($urandom_range(15) == 0) ? 4'($urandom) : 4'h0;
      tick();
      chk($sformatf("random cycle %0d", i), {19'd0, rise, fall, pend, irq, cnt}, model_pack());
    end
    model_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
